// File: rtl/rs_issue_queue.sv
// ----------------------------------------------------------------------------
// CORE_PKG: core-wide sizing constants and the dispatch/issue packet formats
// shared between rename/dispatch, the reservation station and the FUs.
// ----------------------------------------------------------------------------
package CORE_PKG;

    localparam int unsigned RS_ENTRIES = 4;
    localparam int unsigned FIRE_WIDTH = 2;
    localparam int unsigned NUM_PREGS  = 64;
    localparam int unsigned PW         = $clog2(NUM_PREGS);

    typedef struct packed {
        logic [5:0]    opcode;
        logic [PW-1:0] dst_preg;
        logic [PW-1:0] src1_preg;
        logic [PW-1:0] src2_preg;
        logic [15:0]   imm;
    } disp_packet_t;

    typedef struct packed {
        logic [5:0]    opcode;
        logic [PW-1:0] dst_preg;
        logic [PW-1:0] src1_preg;
        logic [PW-1:0] src2_preg;
        logic [15:0]   imm;
        logic [31:0]   src1_val;
        logic [31:0]   src2_val;
    } exec_packet_t;

endpackage

// ----------------------------------------------------------------------------
// rs_issue_queue: compacting reservation station, oldest entry in slot 0.
// Holds dispatched instructions until both sources are ready, picks the oldest
// ready entry, reads its operands from the register file and presents a
// registered exec packet with a valid/ready handshake.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   flush               drop all entries and the output packet
//   disp_valid/ready    dispatch handshake (ready = a free slot exists)
//   disp_pkt            instruction being dispatched
//   disp_src1/2_rdy     busy-table readiness of the sources at dispatch
//   wk_valid/wk_preg    wakeup broadcast of physical registers written
//   rf_raddr1/2         combinational register-file read addresses
//   rf_rdata1/2         same-cycle register-file read data
//   iss_valid/ready     issue handshake toward the functional unit
//   iss_pkt             registered issue packet
//   occupancy           number of valid entries
// ----------------------------------------------------------------------------
module rs_issue_queue #(
    parameter int unsigned RS_ENTRIES = CORE_PKG::RS_ENTRIES,
    parameter int unsigned NUM_WAKEUP = CORE_PKG::FIRE_WIDTH
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    flush,
    input  logic                                    disp_valid,
    output logic                                    disp_ready,
    input  CORE_PKG::disp_packet_t                  disp_pkt,
    input  logic                                    disp_src1_rdy,
    input  logic                                    disp_src2_rdy,
    input  logic [NUM_WAKEUP-1:0]                   wk_valid,
    input  logic [NUM_WAKEUP-1:0][CORE_PKG::PW-1:0] wk_preg,
    output logic [CORE_PKG::PW-1:0]                 rf_raddr1,
    output logic [CORE_PKG::PW-1:0]                 rf_raddr2,
    input  logic [31:0]                             rf_rdata1,
    input  logic [31:0]                             rf_rdata2,
    output logic                                    iss_valid,
    output CORE_PKG::exec_packet_t                  iss_pkt,
    input  logic                                    iss_ready,
    output logic [$clog2(RS_ENTRIES):0]             occupancy
);

    localparam int unsigned PW = CORE_PKG::PW;
    localparam int unsigned IW = (RS_ENTRIES > 1) ? $clog2(RS_ENTRIES) : 1;
    localparam int unsigned OW = $clog2(RS_ENTRIES) + 1;
    localparam logic [OW-1:0] FULL_CNT = OW'(RS_ENTRIES);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [RS_ENTRIES-1:0]  vld_q,    vld_d;
    logic [RS_ENTRIES-1:0]  s1_rdy_q, s1_rdy_d;
    logic [RS_ENTRIES-1:0]  s2_rdy_q, s2_rdy_d;
    CORE_PKG::disp_packet_t pkt_q [RS_ENTRIES];
    CORE_PKG::disp_packet_t pkt_d [RS_ENTRIES];
    logic                   iss_valid_q, iss_valid_d;
    CORE_PKG::exec_packet_t iss_pkt_q,   iss_pkt_d;
    logic [OW-1:0]          occ_q,       occ_d;

    // ------------------------------------------------------------------------
    // Combinational working signals
    // ------------------------------------------------------------------------
    logic                   disp_fire;
    logic                   out_free;
    logic [RS_ENTRIES-1:0]  cand;
    logic                   win_found;
    logic [IW-1:0]          win_idx;
    logic                   sel_fire;
    CORE_PKG::disp_packet_t rd_pkt;
    logic [IW-1:0]          tail_idx;

    // One spare slot above the top entry, always invalid, so the compaction
    // loop can read slot i+1 uniformly for every i.
    logic [RS_ENTRIES:0]    vld_x, s1_x, s2_x;
    CORE_PKG::disp_packet_t pkt_x [RS_ENTRIES+1];

    // True when any valid wakeup port carries this physical register.
    function automatic logic woken(input logic [PW-1:0] preg);
        logic hit;
        hit = 1'b0;
        for (int unsigned w = 0; w < NUM_WAKEUP; w++) begin
            if (wk_valid[w] && (wk_preg[w] == preg)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // ------------------------------------------------------------------------
    // Handshake status, derived from registered state only
    // ------------------------------------------------------------------------
    always_comb begin
        disp_ready = (occ_q < FULL_CNT);
        disp_fire  = disp_valid && disp_ready;
        out_free   = !iss_valid_q || iss_ready;
    end

    // ------------------------------------------------------------------------
    // Select: oldest entry whose registered ready bits are both set
    // ------------------------------------------------------------------------
    always_comb begin
        cand      = vld_q & s1_rdy_q & s2_rdy_q;
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
            if (cand[i] && !win_found) begin
                win_found = 1'b1;
                win_idx   = IW'(i);
            end
        end
        sel_fire = out_free && win_found;
    end

    // ------------------------------------------------------------------------
    // Register-file read: winner's sources, slot 0 when nothing is selected
    // ------------------------------------------------------------------------
    always_comb begin
        rd_pkt    = sel_fire ? pkt_q[win_idx] : pkt_q[0];
        rf_raddr1 = rd_pkt.src1_preg;
        rf_raddr2 = rd_pkt.src2_preg;
    end

    // ------------------------------------------------------------------------
    // Entries with this cycle's wakeups applied, plus the empty spare slot
    // ------------------------------------------------------------------------
    always_comb begin
        vld_x = '0;
        s1_x  = '0;
        s2_x  = '0;
        for (int unsigned i = 0; i < RS_ENTRIES + 1; i++) begin
            pkt_x[i] = '0;
        end
        for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
            vld_x[i] = vld_q[i];
            s1_x[i]  = s1_rdy_q[i] | woken(pkt_q[i].src1_preg);
            s2_x[i]  = s2_rdy_q[i] | woken(pkt_q[i].src2_preg);
            pkt_x[i] = pkt_q[i];
        end
    end

    // ------------------------------------------------------------------------
    // Next entry state: compact over the winner, then append the dispatch
    // at the post-compaction tail. Flush overrides everything.
    // ------------------------------------------------------------------------
    always_comb begin
        vld_d    = '0;
        s1_rdy_d = '0;
        s2_rdy_d = '0;
        for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
            if (sel_fire && (IW'(i) >= win_idx)) begin
                vld_d[i]    = vld_x[i+1];
                s1_rdy_d[i] = s1_x[i+1];
                s2_rdy_d[i] = s2_x[i+1];
                pkt_d[i]    = pkt_x[i+1];
            end else begin
                vld_d[i]    = vld_x[i];
                s1_rdy_d[i] = s1_x[i];
                s2_rdy_d[i] = s2_x[i];
                pkt_d[i]    = pkt_x[i];
            end
        end

        // Only meaningful when disp_fire, which guarantees occ_q < RS_ENTRIES.
        tail_idx = IW'(occ_q - OW'(sel_fire));
        if (disp_fire) begin
            vld_d[tail_idx]    = 1'b1;
            pkt_d[tail_idx]    = disp_pkt;
            s1_rdy_d[tail_idx] = disp_src1_rdy | woken(disp_pkt.src1_preg);
            s2_rdy_d[tail_idx] = disp_src2_rdy | woken(disp_pkt.src2_preg);
        end

        // Dispatch is only accepted below full and issue only from a valid
        // entry, so this stays within 0..RS_ENTRIES.
        occ_d = occ_q + OW'(disp_fire) - OW'(sel_fire);

        if (flush) begin
            vld_d    = '0;
            s1_rdy_d = '0;
            s2_rdy_d = '0;
            occ_d    = '0;
        end
    end

    // ------------------------------------------------------------------------
    // Output stage: load on select, hold under backpressure, drain on ready
    // ------------------------------------------------------------------------
    always_comb begin
        iss_valid_d = iss_valid_q;
        iss_pkt_d   = iss_pkt_q;
        if (sel_fire) begin
            iss_valid_d         = 1'b1;
            iss_pkt_d.opcode    = rd_pkt.opcode;
            iss_pkt_d.dst_preg  = rd_pkt.dst_preg;
            iss_pkt_d.src1_preg = rd_pkt.src1_preg;
            iss_pkt_d.src2_preg = rd_pkt.src2_preg;
            iss_pkt_d.imm       = rd_pkt.imm;
            iss_pkt_d.src1_val  = rf_rdata1;
            iss_pkt_d.src2_val  = rf_rdata2;
        end else if (iss_ready) begin
            iss_valid_d = 1'b0;
        end
        if (flush) begin
            iss_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q       <= '0;
            s1_rdy_q    <= '0;
            s2_rdy_q    <= '0;
            occ_q       <= '0;
            iss_valid_q <= 1'b0;
            iss_pkt_q   <= '0;
            for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
                pkt_q[i] <= '0;
            end
        end else begin
            vld_q       <= vld_d;
            s1_rdy_q    <= s1_rdy_d;
            s2_rdy_q    <= s2_rdy_d;
            occ_q       <= occ_d;
            iss_valid_q <= iss_valid_d;
            iss_pkt_q   <= iss_pkt_d;
            for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
                pkt_q[i] <= pkt_d[i];
            end
        end
    end

    assign iss_valid = iss_valid_q;
    assign iss_pkt   = iss_pkt_q;
    assign occupancy = occ_q;

endmodule

// File: tb/tb_rs_issue_queue.sv
// ----------------------------------------------------------------------------
// tb_rs_issue_queue: directed scenarios followed by randomized traffic.
// A queue-based reference model advances on each rising edge from the bench's
// own inputs; a separate monitor compares the DUT's outputs against it and
// pops the expected issue packet on each completed handshake.
// ----------------------------------------------------------------------------
module tb_rs_issue_queue;

    localparam int unsigned PW   = CORE_PKG::PW;
    localparam int          RS_N = 4;

    logic                         clk;
    logic                         rst;
    logic                         flush;
    logic                         disp_valid;
    logic                         disp_ready;
    CORE_PKG::disp_packet_t       disp_pkt;
    logic                         disp_src1_rdy;
    logic                         disp_src2_rdy;
    logic [1:0]                   wk_valid;
    logic [1:0][PW-1:0]           wk_preg;
    logic [PW-1:0]                rf_raddr1;
    logic [PW-1:0]                rf_raddr2;
    logic [31:0]                  rf_rdata1;
    logic [31:0]                  rf_rdata2;
    logic                         iss_valid;
    CORE_PKG::exec_packet_t       iss_pkt;
    logic                         iss_ready;
    logic [2:0]                   occupancy;

    logic [31:0] rf_mem [CORE_PKG::NUM_PREGS];

    rs_issue_queue #(
        .RS_ENTRIES (4),
        .NUM_WAKEUP (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .disp_valid    (disp_valid),
        .disp_ready    (disp_ready),
        .disp_pkt      (disp_pkt),
        .disp_src1_rdy (disp_src1_rdy),
        .disp_src2_rdy (disp_src2_rdy),
        .wk_valid      (wk_valid),
        .wk_preg       (wk_preg),
        .rf_raddr1     (rf_raddr1),
        .rf_raddr2     (rf_raddr2),
        .rf_rdata1     (rf_rdata1),
        .rf_rdata2     (rf_rdata2),
        .iss_valid     (iss_valid),
        .iss_pkt       (iss_pkt),
        .iss_ready     (iss_ready),
        .occupancy     (occupancy)
    );

    // Register file behind the read ports.
    assign rf_rdata1 = rf_mem[rf_raddr1];
    assign rf_rdata2 = rf_mem[rf_raddr2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference model: ordered list of waiting instructions, one output slot
    // ------------------------------------------------------------------------
    typedef struct {
        CORE_PKG::disp_packet_t p;
        bit                     r1;
        bit                     r2;
    } m_ent_t;

    m_ent_t                 m_q[$];
    CORE_PKG::exec_packet_t sb[$];
    bit                     m_out_valid;
    bit                     m_fresh;
    bit                     mon_en;

    int checks;
    int fails;

    function automatic bit woke(input logic [PW-1:0] r);
        for (int w = 0; w < 2; w++) begin
            if (wk_valid[w] && wk_preg[w] == r) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_step();
        int                     win;
        bit                     fire;
        bit                     ofree;
        m_ent_t                 ne;
        CORE_PKG::exec_packet_t e;
        if (rst) begin
            m_q.delete();
            sb.delete();
            m_out_valid = 1'b0;
            m_fresh     = 1'b1;
            return;
        end
        if (flush) begin
            m_q.delete();
            if (m_out_valid) void'(sb.pop_back());
            m_out_valid = 1'b0;
            return;
        end
        fire  = disp_valid && (m_q.size() < RS_N);
        ofree = !m_out_valid || iss_ready;
        if (m_out_valid && iss_ready) m_out_valid = 1'b0;
        win = -1;
        if (ofree) begin
            for (int i = 0; i < m_q.size(); i++) begin
                if (win < 0 && m_q[i].r1 && m_q[i].r2) win = i;
            end
        end
        for (int i = 0; i < m_q.size(); i++) begin
            if (woke(m_q[i].p.src1_preg)) m_q[i].r1 = 1'b1;
            if (woke(m_q[i].p.src2_preg)) m_q[i].r2 = 1'b1;
        end
        if (win >= 0) begin
            e.opcode    = m_q[win].p.opcode;
            e.dst_preg  = m_q[win].p.dst_preg;
            e.src1_preg = m_q[win].p.src1_preg;
            e.src2_preg = m_q[win].p.src2_preg;
            e.imm       = m_q[win].p.imm;
            e.src1_val  = rf_mem[m_q[win].p.src1_preg];
            e.src2_val  = rf_mem[m_q[win].p.src2_preg];
            sb.push_back(e);
            m_q.delete(win);
            m_out_valid = 1'b1;
        end
        if (fire) begin
            ne.p  = disp_pkt;
            ne.r1 = disp_src1_rdy || woke(disp_pkt.src1_preg);
            ne.r2 = disp_src2_rdy || woke(disp_pkt.src2_preg);
            m_q.push_back(ne);
            m_fresh = 1'b0;
        end
    endtask

    // ------------------------------------------------------------------------
    // Monitor: samples mid-cycle, after inputs settle and before the edge
    // ------------------------------------------------------------------------
    function automatic void chk(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        #3;
        if (mon_en) begin
            int          idx;
            logic [PW-1:0] e1;
            logic [PW-1:0] e2;
            bit          have;
            chk("occupancy", 128'(occupancy), 128'(m_q.size()));
            chk("disp_ready", 128'(disp_ready), 128'(m_q.size() < RS_N));
            chk("iss_valid", 128'(iss_valid), 128'(m_out_valid));
            if (m_out_valid) begin
                if (sb.size() == 0) begin
                    chk("scoreboard_nonempty", 128'(0), 128'(1));
                end else begin
                    chk("iss_pkt", 128'(iss_pkt), 128'(sb[0]));
                    if (iss_ready && !flush && !rst) void'(sb.pop_front());
                end
            end
            // Expected read addresses: current winner, else oldest entry.
            idx  = -1;
            have = 1'b0;
            e1   = '0;
            e2   = '0;
            if (!m_out_valid || iss_ready) begin
                for (int i = 0; i < m_q.size(); i++) begin
                    if (idx < 0 && m_q[i].r1 && m_q[i].r2) idx = i;
                end
            end
            if (idx >= 0) begin
                e1 = m_q[idx].p.src1_preg; e2 = m_q[idx].p.src2_preg; have = 1'b1;
            end else if (m_q.size() > 0) begin
                e1 = m_q[0].p.src1_preg; e2 = m_q[0].p.src2_preg; have = 1'b1;
            end else if (m_fresh) begin
                have = 1'b1;
            end
            if (have) begin
                chk("rf_raddr1", 128'(rf_raddr1), 128'(e1));
                chk("rf_raddr2", 128'(rf_raddr2), 128'(e2));
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        rst        = 1'b0;
        flush      = 1'b0;
        disp_valid = 1'b0;
        wk_valid   = '0;
    endtask

    task automatic set_disp(input int s1, input int s2, input bit r1, input bit r2);
        disp_valid         = 1'b1;
        disp_pkt.opcode    = 6'($urandom);
        disp_pkt.dst_preg  = PW'($urandom);
        disp_pkt.src1_preg = PW'(s1);
        disp_pkt.src2_preg = PW'(s2);
        disp_pkt.imm       = 16'($urandom);
        disp_src1_rdy      = r1;
        disp_src2_rdy      = r2;
    endtask

    initial begin
        checks      = 0;
        fails       = 0;
        mon_en      = 1'b0;
        m_out_valid = 1'b0;
        m_fresh     = 1'b1;
        for (int i = 0; i < int'(CORE_PKG::NUM_PREGS); i++) rf_mem[i] = $urandom;
        rf_mem[5] = 32'h11;
        rf_mem[6] = 32'h22;
        wk_valid  = '0;
        wk_preg   = '0;
        flush     = 1'b0;
        iss_ready = 1'b1;

        // Reset held two cycles with a dispatch offered.
        rst = 1'b1; set_disp(1, 2, 1, 1);
        tick();
        mon_en = 1'b1;
        rst = 1'b1; set_disp(1, 2, 1, 1);
        tick();
        tick();

        // Ready dispatch issues on the next edge.
        iss_ready = 1'b1;
        set_disp(5, 6, 1, 1);
        tick(); tick(); tick();

        // A waits on p7, younger B is ready and goes first; wakeup on port 1.
        set_disp(7, 6, 0, 1); tick();
        set_disp(5, 6, 1, 1); tick();
        tick(); tick();
        wk_valid = 2'b10; wk_preg[1] = PW'(7);
        tick(); tick(); tick();

        // Backpressure: fill the queue behind a held output packet.
        iss_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_disp(i + 1, i + 2, 1, 1);
            tick();
        end
        tick(); tick();
        iss_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();

        // Dispatch whose source is woken in the same cycle.
        set_disp(5, 9, 1, 0); wk_valid = 2'b01; wk_preg[0] = PW'(9);
        tick(); tick(); tick();

        // Flush with three entries, a held output and a dispatch offered.
        iss_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_disp(i + 3, i + 4, 1, 1);
            tick();
        end
        flush = 1'b1; set_disp(5, 6, 1, 1);
        tick(); tick();
        iss_ready = 1'b1;
        tick();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(99) < 60)
                set_disp($urandom_range(15), $urandom_range(15),
                         $urandom_range(1) == 1, $urandom_range(1) == 1);
            wk_valid   = 2'($urandom);
            wk_preg[0] = PW'($urandom_range(15));
            wk_preg[1] = PW'($urandom_range(15));
            iss_ready  = $urandom_range(99) < 70;
            flush      = $urandom_range(99) < 2;
            rst        = $urandom_range(299) == 0;
            tick();
        end

        // Drain with every source woken.
        iss_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            wk_valid   = 2'b11;
            wk_preg[0] = PW'(c % 16);
            wk_preg[1] = PW'((c + 8) % 16);
            tick();
        end
        tick();
        #4;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
